// File: rtl/join_fork_collector.sv
// -----------------------------------------------------------------------------
// join_fork_collector
//
// Purpose:
//   Downstream consumer of the join/fork token network. Watches the four
//   token levels (a, b, c, d), turns rising edges into tokens and collects
//   them into sets. When all four branches have fired at least once the set
//   is complete: o_done pulses for one cycle and o_count advances (wrapping).
//   An optional watchdog ends a set that stalls in COLLECT.
//
// Optional feature macro:
//   JOIN_COLLECT_TIMEOUT_EN - when defined, the timeout timer, the TIMEOUT
//   state, o_timeout and o_missing are present. When undefined, COLLECT waits
//   indefinitely and o_timeout / o_missing are tied to 0. The port list is the
//   same in both builds.
//
// Ports:
//   clk        in   1      single clock, all state on the rising edge
//   rst        in   1      asynchronous, active-low reset
//   i_a..i_d   in   1      token levels from branches a..d
//   o_done     out  1      1-cycle pulse when all four branches have fired
//   o_timeout  out  1      1-cycle pulse on watchdog expiry
//   o_missing  out  4      {d,c,b,a} branches absent at the last timeout,
//                          held until the next done/timeout
//   o_dup      out  1      1-cycle pulse when a collected branch fires again
//   o_busy     out  1      high while collecting a partial set
//   o_mask     out  4      {d,c,b,a} branches collected in the current set
//   o_count    out  CNT_W  completed joins, wraps to 0
// -----------------------------------------------------------------------------
module join_fork_collector #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 16,
  parameter int TMR_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_c,
  input  logic             i_d,
  output logic             o_done,
  output logic             o_timeout,
  output logic [3:0]       o_missing,
  output logic             o_dup,
  output logic             o_busy,
  output logic [3:0]       o_mask,
  output logic [CNT_W-1:0] o_count
);

  // Elaboration-time guard on the timeout window.
  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > ((1 << TMR_W) - 1))) begin : g_bad_timeout
    $error("join_fork_collector: TIMEOUT_CYC out of range for TMR_W");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  // DONE, TIMEOUT and IDLE all treat the current cycle's tokens as the start
  // of a fresh set, so they share this decision.
  function automatic state_t f_open(input logic [3:0] tok);
    state_t s;
    if (tok == 4'hF) begin
      s = S_DONE;
    end else if (tok != 4'h0) begin
      s = S_COLLECT;
    end else begin
      s = S_IDLE;
    end
    return s;
  endfunction

  state_t           r_state;
  state_t           w_state_n;
  logic [3:0]       w_in;
  logic [3:0]       w_tok;
  logic [3:0]       w_merge;
  logic [3:0]       r_prev;
  logic [3:0]       r_mask;
  logic [3:0]       w_mask_n;
  logic             r_done;
  logic             w_done_n;
  logic             r_dup;
  logic             w_dup_n;
  logic             r_busy;
  logic             w_busy_n;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_n;

  assign w_in    = {i_d, i_c, i_b, i_a};
  // A held level counts once: only a 0->1 change is a token.
  assign w_tok   = w_in & ~r_prev;
  assign w_merge = r_mask | w_tok;

`ifdef JOIN_COLLECT_TIMEOUT_EN
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_n;
  logic             w_expire;
  logic             r_timeout;
  logic             w_timeout_n;
  logic [3:0]       r_missing;
  logic [3:0]       w_missing_n;

  assign w_expire = (r_timer == TMR_W'(TIMEOUT_CYC - 1));
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state decision; completion wins over expiry in the same cycle.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: begin
        w_state_n = f_open(w_tok);
      end
      S_COLLECT: begin
        if (w_merge == 4'hF) begin
          w_state_n = S_DONE;
`ifdef JOIN_COLLECT_TIMEOUT_EN
        end else if (w_expire) begin
          w_state_n = S_TIMEOUT;
`endif
        end else begin
          w_state_n = S_COLLECT;
        end
      end
      S_DONE: begin
        w_state_n = f_open(w_tok);
      end
`ifdef JOIN_COLLECT_TIMEOUT_EN
      S_TIMEOUT: begin
        w_state_n = f_open(w_tok);
      end
`endif
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    w_done_n  = 1'b0;
    w_dup_n   = 1'b0;
    w_busy_n  = (w_state_n == S_COLLECT);
    w_count_n = r_count;
    w_mask_n  = r_mask;
`ifdef JOIN_COLLECT_TIMEOUT_EN
    w_timer_n   = r_timer;
    w_timeout_n = 1'b0;
    w_missing_n = r_missing;
`endif
    case (r_state)
      S_COLLECT: begin
        // A repeated branch is flagged but never double-counted.
        w_dup_n  = |(w_tok & r_mask);
        w_mask_n = w_merge;
`ifdef JOIN_COLLECT_TIMEOUT_EN
        w_timer_n = r_timer + TMR_W'(1);
`endif
      end
      S_IDLE, S_DONE, S_TIMEOUT: begin
        // The previous set is finished; this cycle's tokens start a new one.
        w_mask_n = w_tok;
`ifdef JOIN_COLLECT_TIMEOUT_EN
        w_timer_n = {TMR_W{1'b0}};
`endif
      end
      default: begin
        w_mask_n = 4'h0;
      end
    endcase

    if (w_state_n == S_DONE) begin
      // Mask shows the completed set (4'hF) during the done cycle.
      w_done_n  = 1'b1;
      w_count_n = r_count + CNT_W'(1);
`ifdef JOIN_COLLECT_TIMEOUT_EN
      w_missing_n = 4'h0;
`endif
`ifdef JOIN_COLLECT_TIMEOUT_EN
    end else if (w_state_n == S_TIMEOUT) begin
      // Tokens arriving in the expiry cycle are credited, not reported missing.
      w_timeout_n = 1'b1;
      w_missing_n = ~w_merge;
`endif
    end else begin
      w_count_n = r_count;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev  <= 4'h0;
      r_mask  <= 4'h0;
      r_done  <= 1'b0;
      r_dup   <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_prev  <= w_in;
      r_mask  <= w_mask_n;
      r_done  <= w_done_n;
      r_dup   <= w_dup_n;
      r_busy  <= w_busy_n;
      r_count <= w_count_n;
    end
  end

`ifdef JOIN_COLLECT_TIMEOUT_EN
  // Watchdog timer and timeout reporting registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer   <= {TMR_W{1'b0}};
      r_timeout <= 1'b0;
      r_missing <= 4'h0;
    end else begin
      r_timer   <= w_timer_n;
      r_timeout <= w_timeout_n;
      r_missing <= w_missing_n;
    end
  end

  assign o_timeout = r_timeout;
  assign o_missing = r_missing;
`else
  assign o_timeout = 1'b0;
  assign o_missing = 4'h0;
`endif

  assign o_done  = r_done;
  assign o_dup   = r_dup;
  assign o_busy  = r_busy;
  assign o_mask  = r_mask;
  assign o_count = r_count;

endmodule

// File: tb/tb_join_fork_collector.sv
module tb_join_fork_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_a, i_b, i_c, i_d;
  logic       o_done, o_timeout, o_dup, o_busy;
  logic [3:0] o_missing, o_mask;
  logic [7:0] o_count;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  join_fork_collector #(.CNT_W(8), .TIMEOUT_CYC(16), .TMR_W(5)) dut (
    .clk(clk), .rst(rst),
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d),
    .o_done(o_done), .o_timeout(o_timeout), .o_missing(o_missing),
    .o_dup(o_dup), .o_busy(o_busy), .o_mask(o_mask), .o_count(o_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {i_d, i_c, i_b, i_a} = v;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected count for every set the stimulus completes.
  task automatic push_set();
    exp_count = (exp_count + 1) % 256;
    sb_q.push_back(exp_count);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"},    32'(o_done),    32'd0);
    chk({tag, "_timeout"}, 32'(o_timeout), 32'd0);
    chk({tag, "_missing"}, 32'(o_missing), 32'd0);
    chk({tag, "_dup"},     32'(o_dup),     32'd0);
    chk({tag, "_busy"},    32'(o_busy),    32'd0);
    chk({tag, "_mask"},    32'(o_mask),    32'd0);
    chk({tag, "_count"},   32'(o_count),   32'd0);
  endtask

  // Scoreboard: every done pulse must match the oldest expected set.
  always @(negedge clk) begin
    if (rst === 1'b1 && o_done === 1'b1) begin
      chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        chk("sb_count", 32'(o_count), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wrapped;
    int prev;
    rst = 1'b0;
    drive(4'h0);
    tick();
    tick();
    chk_zero("reset");

    // Mid-run reset with all inputs high, then one edge each after release
    rst = 1'b1;
    drive(4'h1);
    tick();
    chk("t1_busy", 32'(o_busy), 32'd1);
    chk("t1_mask", 32'(o_mask), 32'h1);
    drive(4'hF);
    rst = 1'b0;
    #1;
    chk_zero("t1_async");
    tick();
    chk_zero("t1_held");
    rst = 1'b1;
    push_set();
    tick();
    chk("t1_done", 32'(o_done), 32'd1);
    chk("t1_count", 32'(o_count), 32'd1);
    chk("t1_busy_done", 32'(o_busy), 32'd0);
    tick();
    chk("t1_done_off", 32'(o_done), 32'd0);
    chk("t1_count_hold", 32'(o_count), 32'd1);
    chk("t1_mask_clr", 32'(o_mask), 32'd0);
    drive(4'h0);
    tick();

    // Simultaneous rise
    drive(4'hF);
    push_set();
    tick();
    chk("t2_done", 32'(o_done), 32'd1);
    chk("t2_busy", 32'(o_busy), 32'd0);
    chk("t2_count", 32'(o_count), 32'd2);
    tick();
    chk("t2_done_off", 32'(o_done), 32'd0);
    chk("t2_busy_off", 32'(o_busy), 32'd0);
    drive(4'h0);
    tick();

    // Staggered a, c, b, d
    drive(4'h1); tick();
    chk("t3_mask1", 32'(o_mask), 32'h1);
    chk("t3_busy", 32'(o_busy), 32'd1);
    tick();
    chk("t3_mask1h", 32'(o_mask), 32'h1);
    drive(4'h5); tick();
    chk("t3_mask5", 32'(o_mask), 32'h5);
    chk("t3_dup5", 32'(o_dup), 32'd0);
    tick();
    drive(4'h7); tick();
    chk("t3_mask7", 32'(o_mask), 32'h7);
    chk("t3_done7", 32'(o_done), 32'd0);
    tick();
    drive(4'hF);
    push_set();
    tick();
    chk("t3_maskF", 32'(o_mask), 32'hF);
    chk("t3_done", 32'(o_done), 32'd1);
    chk("t3_count", 32'(o_count), 32'd3);
    chk("t3_dup", 32'(o_dup), 32'd0);
    drive(4'h0); tick();
    chk("t3_done_off", 32'(o_done), 32'd0);

    // Duplicate a before b, c, d
    drive(4'h1); tick();
    chk("t4_mask_a", 32'(o_mask), 32'h1);
    drive(4'h0); tick();
    chk("t4_dup_none", 32'(o_dup), 32'd0);
    drive(4'h1); tick();
    chk("t4_dup", 32'(o_dup), 32'd1);
    chk("t4_mask_dup", 32'(o_mask), 32'h1);
    drive(4'h0); tick();
    chk("t4_dup_off", 32'(o_dup), 32'd0);
    chk("t4_mask_hold", 32'(o_mask), 32'h1);
    drive(4'h2); tick();
    chk("t4_mask3", 32'(o_mask), 32'h3);
    drive(4'h6); tick();
    chk("t4_mask7", 32'(o_mask), 32'h7);
    drive(4'hE);
    push_set();
    tick();
    chk("t4_done", 32'(o_done), 32'd1);
    drive(4'h0); tick();
    chk("t4_done_off", 32'(o_done), 32'd0);

    // Only a and b fire
    drive(4'h3); tick();
    chk("t5_mask", 32'(o_mask), 32'h3);
    chk("t5_busy0", 32'(o_busy), 32'd1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_busy", 32'(o_busy), 32'd1);
      chk("t5_no_to", 32'(o_timeout), 32'd0);
    end
    tick();
`ifdef JOIN_COLLECT_TIMEOUT_EN
    chk("t5_timeout", 32'(o_timeout), 32'd1);
    chk("t5_missing", 32'(o_missing), 32'hC);
    chk("t5_busy_to", 32'(o_busy), 32'd0);
    chk("t5_count", 32'(o_count), 32'(exp_count));
    tick();
    chk("t5_to_off", 32'(o_timeout), 32'd0);
    chk("t5_missing_sticky", 32'(o_missing), 32'hC);
    chk("t5_idle", 32'(o_busy), 32'd0);
    drive(4'h0); tick();
`else
    chk("t5_off_timeout", 32'(o_timeout), 32'd0);
    chk("t5_off_busy", 32'(o_busy), 32'd1);
    chk("t5_off_missing", 32'(o_missing), 32'd0);
    drive(4'hF);
    push_set();
    tick();
    chk("t5_off_done", 32'(o_done), 32'd1);
    drive(4'h0); tick();
`endif

    // New token in the DONE cycle opens the next set
    drive(4'h1); tick();
    drive(4'h2); tick();
    chk("t6_mask3", 32'(o_mask), 32'h3);
    drive(4'h4); tick();
    drive(4'h8);
    push_set();
    tick();
    chk("t6_done", 32'(o_done), 32'd1);
    chk("t6_missing_clr", 32'(o_missing), 32'd0);
    drive(4'h9); tick();
    chk("t6_new_mask", 32'(o_mask), 32'h1);
    chk("t6_new_busy", 32'(o_busy), 32'd1);
    chk("t6_new_done", 32'(o_done), 32'd0);
    drive(4'h0); tick();
    chk("t6_mask_keep", 32'(o_mask), 32'h1);
    drive(4'hE);
    push_set();
    tick();
    chk("t6_done2", 32'(o_done), 32'd1);
    drive(4'h0); tick();

    // Full sets until the counter wraps
    wrapped = 1'b0;
    for (int n = 0; n < 300 && !wrapped; n++) begin
      prev = exp_count;
      drive(4'hF);
      push_set();
      tick();
      chk("wr_done", 32'(o_done), 32'd1);
      chk("wr_count", 32'(o_count), 32'(exp_count));
      if (prev == 255) begin
        chk("wr_wrap", 32'(o_count), 32'd0);
        wrapped = 1'b1;
      end
      drive(4'h0);
      tick();
      chk("wr_done_off", 32'(o_done), 32'd0);
      chk("wr_hold", 32'(o_count), 32'(exp_count));
    end
    chk("wr_reached", 32'(wrapped), 32'd1);
    chk("end_missing", 32'(o_missing), 32'd0);
    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
